// File: rtl/binary_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : binary_to_bcd_seq
// Purpose  : Iterative double-dabble (shift-and-add-3) binary to packed BCD
//            converter. One input bit is consumed per clock; one conversion
//            is in flight at a time, with ready/valid handshakes on both sides.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            in_valid/in_ready     - input handshake (in_ready == IDLE)
//            bin_in [BIN_W]        - unsigned binary value, sampled on accept
//            out_valid/out_ready   - output handshake
//            bcd_out [4*DIGITS]    - packed BCD, ones digit at [3:0]
//            busy                  - high while iterating
// Revision : 1.0 - initial release
// ============================================================================
module binary_to_bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy
);

  localparam int c_BCD_W  = 4 * DIGITS;
  localparam int c_WORK_W = c_BCD_W + BIN_W;
  localparam int c_CNT_W  = $clog2(BIN_W + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(BIN_W);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  // Elaboration-time legality checks on the parameters.
  generate
    if (BIN_W < 4 || BIN_W > 16) begin : g_bad_bin_w
      $error("binary_to_bcd_seq: BIN_W=%0d outside 4..16", BIN_W);
    end
    if (pow10(DIGITS) <= ((longint'(1) << BIN_W) - 1)) begin : g_bad_digits
      $error("binary_to_bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_WORK_W-1:0]   r_work;     // {bcd field, remaining binary bits}
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_BCD_W-1:0]    r_bcd_out;
  logic                  r_out_valid;
  logic                  r_busy;

  logic [c_WORK_W-1:0]   w_adj;
  logic [c_WORK_W-1:0]   w_shift;

  // Add-3 correction applied to every BCD digit on pre-shift values, so that
  // after the shift each digit stays in 0..9 and carries ripple correctly.
  always_comb begin
    w_adj = r_work;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_work[BIN_W + 4*d +: 4] >= 4'd5)
        w_adj[BIN_W + 4*d +: 4] = r_work[BIN_W + 4*d +: 4] + 4'd3;
    end
    w_shift = w_adj << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_bcd_out   <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work  <= {{c_BCD_W{1'b0}}, bin_in};
            r_cnt   <= c_CNT_LOAD;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_work <= w_shift;
          r_cnt  <= r_cnt - c_CNT_LAST;
          // Counter at 1 means this edge performs the last iteration.
          if (r_cnt == c_CNT_LAST) begin
            r_bcd_out   <= w_shift[c_WORK_W-1 -: c_BCD_W];
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign bcd_out   = r_bcd_out;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_binary_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_binary_to_bcd_seq
// Purpose  : Directed and randomised self-checking bench for binary_to_bcd_seq
//            (default BIN_W=10, DIGITS=4).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_binary_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  bin_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] bcd_out;
  logic        busy;

  int checks;
  int failures;

  binary_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decimal split, independent of the shift-and-add algorithm.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'((v)        % 10);
    r[7:4]   = 4'((v / 10)   % 10);
    r[11:8]  = 4'((v / 100)  % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  // Drives one conversion; lat = edges from acceptance to out_valid seen.
  task automatic convert(input logic [9:0] v, input logic early_ready,
                         output logic [15:0] res, output int lat, output bit to);
    int n;
    to = 1'b0; lat = 0; res = '0;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin to = 1'b1; return; end
    bin_in = v; in_valid = 1'b1; out_ready = early_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; bin_in = ~v;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!out_valid) begin to = 1'b1; return; end
    res = bcd_out;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] res; int lat; bit to;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bin_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, bcd_out} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b busy=%b bcd=%h, want 1 0 0 0000",
               in_ready, out_valid, busy, bcd_out);
    end
    rst_n = 1'b1;
    convert(10'd0, 1'b1, res, lat, to);
    checks++;
    if (to || lat != 10) begin
      failures++;
      $display("FAIL zero_latency: got lat=%0d timeout=%0b, want 10", lat, to);
    end
    checks++;
    if (res !== 16'h0000) begin
      failures++;
      $display("FAIL zero_value: got %h, want 0000", res);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_handoff: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed;
    logic [9:0]  vin [7] = '{10'd12, 10'd45, 10'd99, 10'd123, 10'd255, 10'd999, 10'd1023};
    logic [15:0] vex [7] = '{16'h0012, 16'h0045, 16'h0099, 16'h0123, 16'h0255, 16'h0999, 16'h1023};
    logic [15:0] res; int lat; bit to;
    for (int i = 0; i < 7; i++) begin
      convert(vin[i], 1'b0, res, lat, to);
      checks++;
      if (to || res !== vex[i] || lat != 10) begin
        failures++;
        $display("FAIL directed_%0d: got bcd=%h lat=%0d timeout=%0b, want bcd=%h lat=10",
                 vin[i], res, lat, to, vex[i]);
      end
    end
  endtask

  task automatic test_round_trip;
    logic [15:0] res; int lat; bit to; int bad;
    bad = 0;
    for (int h = 0; h < 10; h++)
      for (int t = 0; t < 10; t++)
        for (int o = 0; o < 10; o++) begin
          convert(10'(h*100 + t*10 + o), 1'b1, res, lat, to);
          checks++;
          if (to || res !== {4'd0, 4'(h), 4'(t), 4'(o)}) begin
            failures++;
            if (bad < 10)
              $display("FAIL round_trip: got %h timeout=%0b, want %h",
                       res, to, {4'd0, 4'(h), 4'(t), 4'(o)});
            bad++;
          end
        end
  endtask

  task automatic test_backpressure;
    logic [15:0] res; int n;
    @(negedge clk);
    bin_in = 10'd512; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL bp_timeout: out_valid never rose, want 1");
    end
    for (int i = 0; i < 7; i++) begin
      bin_in = 10'd7; in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || bcd_out !== 16'h0512 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: got ov=%b bcd=%h ir=%b, want 1 0512 0",
                 i, out_valid, bcd_out, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || bcd_out !== 16'h0512 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got ov=%b bcd=%h ir=%b, want 0 0512 1",
               out_valid, bcd_out, in_ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_no_accept: got busy=%b ir=%b, want 0 1", busy, in_ready);
    end
    begin
      int lat; bit to;
      convert(10'd7, 1'b0, res, lat, to);
      checks++;
      if (to || res !== 16'h0007) begin
        failures++;
        $display("FAIL bp_second: got %h timeout=%0b, want 0007", res, to);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] res; int lat; bit to;
    @(negedge clk);
    bin_in = 10'd777; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_busy: got busy=%b ir=%b, want 1 0", busy, in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid, bcd_out, in_ready} !== {1'b0, 1'b0, 16'h0000, 1'b1}) begin
      failures++;
      $display("FAIL mid_reset: got busy=%b ov=%b bcd=%h ir=%b, want 0 0 0000 1",
               busy, out_valid, bcd_out, in_ready);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_discard: got ov=%b, want 0", out_valid);
    end
    rst_n = 1'b1;
    convert(10'd300, 1'b0, res, lat, to);
    checks++;
    if (to || res !== 16'h0300 || lat != 10) begin
      failures++;
      $display("FAIL mid_after: got bcd=%h lat=%0d timeout=%0b, want 0300 lat=10", res, lat, to);
    end
  endtask

  task automatic test_random;
    int v; int n; bit done; logic [15:0] exp_bcd;
    for (int k = 0; k < 200; k++) begin
      v = int'($urandom_range(0, 1023));
      exp_bcd = to_bcd(v);
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      bin_in = 10'(v); in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; bin_in = 10'($urandom);
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
        checks++;
        if (bcd_out[3:0] > 4'd9 || bcd_out[7:4] > 4'd9 ||
            bcd_out[11:8] > 4'd9 || bcd_out[15:12] > 4'd9) begin
          failures++;
          $display("FAIL rand_digit: got %h, want all nibbles <= 9", bcd_out);
        end
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          checks++;
          if (bcd_out !== exp_bcd) begin
            failures++;
            $display("FAIL rand_value_%0d: got %h, want %h", v, bcd_out, exp_bcd);
          end
          done = 1'b1;
        end
        @(negedge clk);
      end
      out_ready = 1'b0;
      if (!done) begin
        checks++;
        failures++;
        $display("FAIL rand_timeout_%0d: got no result, want %h", v, exp_bcd);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bin_in = '0;
    test_reset();
    test_directed();
    test_round_trip();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
